dcache_mshr_file: RTL
=====================

# dcache_mshr_file

Parametrised miss-status holding register file for the standard write-back data cache: it replaces the single-entry `mshr_t` with `NR_ENTRIES` independent entries. Each entry tracks one outstanding line miss from allocation through memory issue to refill. Same-line secondary misses are stalled, and retiring entries are handed back to the requesting port. It sits between the cache controllers and the miss handler's memory-request arbiter.

## Interface
Parameters:
- `NR_ENTRIES`, 4: number of MSHR entries; must be ≥ 2.
- `ADDR_WIDTH`, 56: physical address width.
- `LINE_OFFSET`, 4: line byte-offset bits; these are ignored for line matching.
- `ID_WIDTH`, 2: requester id width.
- `DATA_WIDTH`, 64: write data width. Byte enable width is `DATA_WIDTH/8`.

Ports (`IW = $clog2(NR_ENTRIES)`, `CW = $clog2(NR_ENTRIES+1)`):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous clear of all entries.
- `alloc_valid_i` in 1: allocation request.
- `alloc_ready_o` out 1: allocation accepted when both valid and ready are high.
- `alloc_id_i` in ID_WIDTH: requester id.
- `alloc_we_i` in 1: store miss.
- `alloc_addr_i` in ADDR_WIDTH: miss address.
- `alloc_wdata_i` in DATA_WIDTH: store data.
- `alloc_be_i` in DATA_WIDTH/8: store byte enable.
- `alloc_idx_o` out IW: entry that the current allocation lands in.
- `lookup_addr_i` in ADDR_WIDTH: probe address.
- `lookup_hit_o` out 1: probe line matches an occupied entry.
- `lookup_idx_o` out IW: index of the matching entry.
- `issue_valid_o` out 1: an entry awaits memory issue.
- `issue_ready_i` in 1: memory side accepts the issue.
- `issue_idx_o` out IW: index of the entry being issued.
- `issue_addr_o` out ADDR_WIDTH: line-aligned address (low LINE_OFFSET bits zero).
- `issue_we_o` out 1: issuing entry is a store miss.
- `refill_valid_i` in 1: refill complete for an entry.
- `refill_idx_i` in IW: index of the refilled entry.
- `retire_valid_o` out 1: registered; an entry retired last cycle.
- `retire_id_o` out ID_WIDTH: retired entry's id.
- `retire_we_o` out 1: retired entry's store flag.
- `retire_addr_o` out ADDR_WIDTH: retired entry's address.
- `retire_wdata_o` out DATA_WIDTH: retired entry's store data.
- `retire_be_o` out DATA_WIDTH/8: retired entry's byte enable.
- `count_o` out CW: number of occupied entries.
- `full_o` out 1: all entries occupied.
- `empty_o` out 1: no entries occupied.

## Operation
- Each entry has three states: FREE, WAIT_ISSUE and WAIT_REFILL. An entry is occupied when it is not FREE.
- Line match: compare `addr[ADDR_WIDTH-1:LINE_OFFSET]` against every occupied entry. Match logic is combinational on registered state.
- `alloc_ready_o` = !full && !(alloc line matches an occupied entry) && !flush_i.
- Allocation goes to the lowest-index FREE entry, which moves to WAIT_ISSUE. The entry stores id, we, full address, wdata and be. `alloc_idx_o` is valid whenever `alloc_ready_o` is high.
- Issue arbitration selects the lowest-index WAIT_ISSUE entry. On `issue_valid_o && issue_ready_i` that entry moves to WAIT_REFILL.
- Issue outputs hold stable while `issue_ready_i` is low, unless a flush occurs.
- Refill: on `refill_valid_i`, if entry `refill_idx_i` is in WAIT_REFILL it moves to FREE and its contents are latched onto the retire outputs.
- A refill to an entry in FREE or WAIT_ISSUE is ignored: no state change and no retire. This case is covered by a simulation assertion.
- Flush: every entry moves to FREE. Flush takes priority over alloc, issue and refill in the same cycle, and produces no retire.
- `count_o` equals the popcount of occupied entries; `full_o` = (count == NR_ENTRIES); `empty_o` = (count == 0).

## Timing
- Reset values: all entries FREE; `alloc_ready_o`=1, `issue_valid_o`=0, `retire_valid_o`=0, `lookup_hit_o`=0, `count_o`=0, `full_o`=0, `empty_o`=1. All index and data outputs are 0.
- Allocation handshake at cycle t → entry is in WAIT_ISSUE at t+1; `issue_valid_o` can assert at t+1, never at t.
- Issue handshake at t → entry is in WAIT_REFILL at t+1.
- Refill at t → `retire_valid_o` pulses for exactly one cycle at t+1, and the entry is FREE and allocatable at t+1.
- Simultaneous refill and allocation to the same line in cycle t: allocation stalls in t (match uses registered state) and is accepted at t+1.
- Simultaneous refill of entry k with `full_o`=1: allocation stalls in t and takes entry k at t+1.
- Issue and refill of different entries in the same cycle are both honoured.
- `count_o` reflects registered state; allocation and refill in the same cycle leave it unchanged.
- Reset asserted mid-operation: all state clears immediately (asynchronous reset).

## Test plan
- Reset, then allocate 0x1000, 0x2000, 0x3000, 0x4000 on consecutive cycles → `alloc_idx_o` is 0,1,2,3. `full_o`=1 and `alloc_ready_o`=0 from the 4th cycle after the first handshake. `count_o`=4.
- Continue with `issue_ready_i`=1 → issues idx 0,1,2,3 on four consecutive cycles with `issue_addr_o` 0x1000..0x4000. Then `issue_valid_o`=0.
- `refill_valid_i` with idx 2 (id=3, we=1, wdata=0xDEADBEEF, be=0x0F) → next cycle `retire_valid_o`=1 with those values, `full_o`=0. Next allocation of 0x5000 gets idx 2.
- Allocate 0x1008 while 0x1000 is pending in idx 0 → `alloc_ready_o`=0, `lookup_hit_o`=1, `lookup_idx_o`=0. After refill of idx 0 the allocation is accepted the following cycle, in idx 0.
- `flush_i` with three entries occupied and `alloc_valid_i`=1 → allocation not accepted. Next cycle `empty_o`=1, `issue_valid_o`=0, and no `retire_valid_o`.
- Refill of a FREE entry and of a WAIT_ISSUE entry → no state change, `retire_valid_o` stays 0, and the assertion fires.

Source files
------------

// File: rtl/dcache_mshr_file.sv
// Miss-status holding register file: NR_ENTRIES independent line-miss trackers
// moving FREE -> WAIT_ISSUE -> WAIT_REFILL -> FREE, with same-line stalling.
module dcache_mshr_file #(
   parameter int NR_ENTRIES  = 4,
   parameter int ADDR_WIDTH  = 56,
   parameter int LINE_OFFSET = 4,
   parameter int ID_WIDTH    = 2,
   parameter int DATA_WIDTH  = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic                            alloc_valid_i,
   output logic                            alloc_ready_o,
   input  logic [ID_WIDTH-1:0]             alloc_id_i,
   input  logic                            alloc_we_i,
   input  logic [ADDR_WIDTH-1:0]           alloc_addr_i,
   input  logic [DATA_WIDTH-1:0]           alloc_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]         alloc_be_i,
   output logic [$clog2(NR_ENTRIES)-1:0]   alloc_idx_o,
   input  logic [ADDR_WIDTH-1:0]           lookup_addr_i,
   output logic                            lookup_hit_o,
   output logic [$clog2(NR_ENTRIES)-1:0]   lookup_idx_o,
   output logic                            issue_valid_o,
   input  logic                            issue_ready_i,
   output logic [$clog2(NR_ENTRIES)-1:0]   issue_idx_o,
   output logic [ADDR_WIDTH-1:0]           issue_addr_o,
   output logic                            issue_we_o,
   input  logic                            refill_valid_i,
   input  logic [$clog2(NR_ENTRIES)-1:0]   refill_idx_i,
   output logic                            retire_valid_o,
   output logic [ID_WIDTH-1:0]             retire_id_o,
   output logic                            retire_we_o,
   output logic [ADDR_WIDTH-1:0]           retire_addr_o,
   output logic [DATA_WIDTH-1:0]           retire_wdata_o,
   output logic [DATA_WIDTH/8-1:0]         retire_be_o,
   output logic [$clog2(NR_ENTRIES+1)-1:0] count_o,
   output logic                            full_o,
   output logic                            empty_o
);
   localparam int IW = $clog2(NR_ENTRIES);
   localparam int CW = $clog2(NR_ENTRIES + 1);
   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {FREE = 2'd0, WAIT_ISSUE = 2'd1, WAIT_REFILL = 2'd2} state_e;

   state_e                state_q [NR_ENTRIES];
   logic [ID_WIDTH-1:0]   id_q    [NR_ENTRIES];
   logic                  we_q    [NR_ENTRIES];
   logic [ADDR_WIDTH-1:0] addr_q  [NR_ENTRIES];
   logic [DATA_WIDTH-1:0] wdata_q [NR_ENTRIES];
   logic [BW-1:0]         be_q    [NR_ENTRIES];

   logic          lock_q;
   logic [IW-1:0] lock_idx_q;

   logic          alloc_match, free_found, wi_found, lookup_hit;
   logic [IW-1:0] free_idx, wi_idx, lookup_idx, issue_sel;
   logic [CW-1:0] occ_count;
   logic          issue_valid, alloc_fire, issue_fire, refill_ok;
   logic          lookup_offset_unused;

   assign lookup_offset_unused = ^lookup_addr_i[LINE_OFFSET-1:0];

   // Descending scan so the last assignment wins: every pick is the lowest index.
   always_comb begin
      alloc_match = 1'b0;
      lookup_hit  = 1'b0;
      lookup_idx  = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      wi_found    = 1'b0;
      wi_idx      = '0;
      occ_count   = '0;
      for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] != FREE) begin
            occ_count = occ_count + CW'(1);
            if (addr_q[i][ADDR_WIDTH-1:LINE_OFFSET] == alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET])
               alloc_match = 1'b1;
            if (addr_q[i][ADDR_WIDTH-1:LINE_OFFSET] == lookup_addr_i[ADDR_WIDTH-1:LINE_OFFSET]) begin
               lookup_hit = 1'b1;
               lookup_idx = IW'(i);
            end
         end else begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
         if (state_q[i] == WAIT_ISSUE) begin
            wi_found = 1'b1;
            wi_idx   = IW'(i);
         end
      end
   end

   // A stalled issue stays locked on its entry so a newly allocated lower index cannot
   // swap the request out from under the memory side.
   assign issue_valid = lock_q || wi_found;
   assign issue_sel   = lock_q ? lock_idx_q : wi_idx;
   assign alloc_ready_o = free_found && !alloc_match && !flush_i;
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;
   assign issue_fire    = issue_valid && issue_ready_i;
   assign refill_ok     = refill_valid_i && (state_q[refill_idx_i] == WAIT_REFILL);

   assign alloc_idx_o   = free_idx;
   assign lookup_hit_o  = lookup_hit;
   assign lookup_idx_o  = lookup_idx;
   assign issue_valid_o = issue_valid;
   assign issue_idx_o   = issue_valid ? issue_sel : '0;
   assign issue_addr_o  = issue_valid ?
                          {addr_q[issue_sel][ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}} : '0;
   assign issue_we_o    = issue_valid && we_q[issue_sel];
   assign count_o       = occ_count;
   assign full_o        = (occ_count == CW'(NR_ENTRIES));
   assign empty_o       = (occ_count == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            state_q[i] <= FREE;
            id_q[i]    <= '0;
            we_q[i]    <= 1'b0;
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            be_q[i]    <= '0;
         end
         lock_q         <= 1'b0;
         lock_idx_q     <= '0;
         retire_valid_o <= 1'b0;
         retire_id_o    <= '0;
         retire_we_o    <= 1'b0;
         retire_addr_o  <= '0;
         retire_wdata_o <= '0;
         retire_be_o    <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < NR_ENTRIES; i++) state_q[i] <= FREE;
         lock_q         <= 1'b0;
         retire_valid_o <= 1'b0;
      end else begin
         lock_q         <= issue_valid && !issue_ready_i;
         lock_idx_q     <= issue_sel;
         retire_valid_o <= refill_ok;
         // Refill, issue and alloc target entries in distinct states, so they never collide.
         if (refill_ok) begin
            state_q[refill_idx_i] <= FREE;
            retire_id_o    <= id_q[refill_idx_i];
            retire_we_o    <= we_q[refill_idx_i];
            retire_addr_o  <= addr_q[refill_idx_i];
            retire_wdata_o <= wdata_q[refill_idx_i];
            retire_be_o    <= be_q[refill_idx_i];
         end
         if (issue_fire) state_q[issue_sel] <= WAIT_REFILL;
         if (alloc_fire) begin
            state_q[free_idx] <= WAIT_ISSUE;
            id_q[free_idx]    <= alloc_id_i;
            we_q[free_idx]    <= alloc_we_i;
            addr_q[free_idx]  <= alloc_addr_i;
            wdata_q[free_idx] <= alloc_wdata_i;
            be_q[free_idx]    <= alloc_be_i;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i && refill_valid_i)
         assert (state_q[refill_idx_i] == WAIT_REFILL)
         else $warning("refill of entry %0d ignored: entry is not waiting for refill", refill_idx_i);
   end
`endif

endmodule
